// File: rtl/butterfly_pkg.sv
// Shared constants and arithmetic helpers for the pipelined radix-2 butterfly.
// Helpers work on 64-bit signed values; callers size-cast to their own widths.
package butterfly_pkg;

  localparam int LAT = 4;

  // Half-LSB of the Q1.(tw-1) product scale, used for round-half-up.
  function automatic logic signed [63:0] rnd_const(input int tw);
    return 64'sd1 <<< (tw - 2);
  endfunction

  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] value,
                                                input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/cmul_round.sv
// Two-stage complex multiply M*W with round-half-up back to integer scale.
// Stage 2 holds the four raw products, stage 3 the combined, rounded result.
module cmul_round
  import butterfly_pkg::*;
#(
  parameter int DW_IN = 16,
  parameter int TW    = 16
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [1:0]              i_ld,
  input  logic signed [DW_IN-1:0] i_mr,
  input  logic signed [DW_IN-1:0] i_mi,
  input  logic signed [TW-1:0]    i_wr,
  input  logic signed [TW-1:0]    i_wi,
  output logic signed [DW_IN+1:0] o_zr,
  output logic signed [DW_IN+1:0] o_zi
);

  localparam int PW = DW_IN + TW;
  localparam int SW = PW + 1;
  localparam int ZW = DW_IN + 2;

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] s_re, s_im;

  // NOTE: datapath registers carry no reset; validity lives in the stage
  // valid bits, so resetting wide data would only add fan-out on rst.
  // Sequential state always uses <= so all stages sample pre-edge values.
  always_ff @(posedge clk) begin
    if (en && i_ld[0]) begin
      p_rr <= PW'(i_mr) * PW'(i_wr);
      p_ii <= PW'(i_mi) * PW'(i_wi);
      p_ri <= PW'(i_mr) * PW'(i_wi);
      p_ir <= PW'(i_mi) * PW'(i_wr);
    end
  end

  // One extra bit over the product width absorbs (-1)*(-1) sums without wrap.
  always_comb begin
    s_re = SW'(p_rr) - SW'(p_ii) + SW'(rnd_const(TW));
    s_im = SW'(p_ri) + SW'(p_ir) + SW'(rnd_const(TW));
  end

  always_ff @(posedge clk) begin
    if (en && i_ld[1]) begin
      o_zr <= ZW'(s_re >>> (TW - 1));
      o_zi <= ZW'(s_im >>> (TW - 1));
    end
  end

endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage radix-2 butterfly (DIT or DIF) with per-sample halving,
// saturation, sticky overflow and valid/ready backpressure.
module butterfly_pipe
  import butterfly_pkg::*;
#(
  parameter int DW  = 16,
  parameter int TW  = 16,
  parameter int DIF = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  output logic                 i_rdy,
  input  logic signed [DW-1:0] i_ar,
  input  logic signed [DW-1:0] i_ai,
  input  logic signed [DW-1:0] i_br,
  input  logic signed [DW-1:0] i_bi,
  input  logic signed [TW-1:0] i_wr,
  input  logic signed [TW-1:0] i_wi,
  input  logic                 i_scale,
  output logic                 o_vld,
  input  logic                 o_rdy,
  output logic signed [DW-1:0] o_xr,
  output logic signed [DW-1:0] o_xi,
  output logic signed [DW-1:0] o_yr,
  output logic signed [DW-1:0] o_yi,
  output logic                 o_ovf,
  input  logic                 i_ovf_clr
);

  localparam int AW = DW + 1;            // pass-through operand (A or A+B)
  localparam int MW = DW + (DIF != 0);   // multiplicand (B or A-B)
  localparam int ZW = MW + 2;
  localparam int EW = DW + 4;

  logic [LAT-1:0] vld;
  logic           stall, adv;

  logic signed [AW-1:0] p_re_n, p_im_n, p1_re, p1_im, p2_re, p2_im, p3_re, p3_im;
  logic signed [MW-1:0] m_re_n, m_im_n, m1_re, m1_im;
  logic signed [TW-1:0] w1_re, w1_im;
  logic                 sc1, sc2, sc3, ovf4;
  logic signed [ZW-1:0] z_re, z_im;

  logic signed [EW-1:0] x_re_pre, x_im_pre, y_re_pre, y_im_pre;
  logic signed [EW-1:0] pre [4];
  logic signed [EW-1:0] scl [4];
  logic signed [63:0]   sat [4];
  logic signed [DW-1:0] res [4];
  logic [3:0]           hit;

  assign stall = vld[LAT-1] & ~o_rdy;
  assign adv   = ~stall;
  assign i_rdy = adv;
  assign o_vld = vld[LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld <= '0;
    else if (adv) vld <= {vld[LAT-2:0], i_vld};
  end

  generate
    if (DIF != 0) begin : g_dif
      assign p_re_n   = AW'(i_ar) + AW'(i_br);
      assign p_im_n   = AW'(i_ai) + AW'(i_bi);
      assign m_re_n   = AW'(i_ar) - AW'(i_br);
      assign m_im_n   = AW'(i_ai) - AW'(i_bi);
      assign x_re_pre = EW'(p3_re);
      assign x_im_pre = EW'(p3_im);
      assign y_re_pre = EW'(z_re);
      assign y_im_pre = EW'(z_im);
    end else begin : g_dit
      assign p_re_n   = AW'(i_ar);
      assign p_im_n   = AW'(i_ai);
      assign m_re_n   = i_br;
      assign m_im_n   = i_bi;
      assign x_re_pre = EW'(p3_re) + EW'(z_re);
      assign x_im_pre = EW'(p3_im) + EW'(z_im);
      assign y_re_pre = EW'(p3_re) - EW'(z_re);
      assign y_im_pre = EW'(p3_im) - EW'(z_im);
    end
  endgenerate

  // Data only loads behind a valid sample, so bubbles leave the last values.
  always_ff @(posedge clk) begin
    if (adv && i_vld) begin
      p1_re <= p_re_n;  p1_im <= p_im_n;
      m1_re <= m_re_n;  m1_im <= m_im_n;
      w1_re <= i_wr;    w1_im <= i_wi;
      sc1   <= i_scale;
    end
    if (adv && vld[0]) begin
      p2_re <= p1_re;  p2_im <= p1_im;  sc2 <= sc1;
    end
    if (adv && vld[1]) begin
      p3_re <= p2_re;  p3_im <= p2_im;  sc3 <= sc2;
    end
  end

  cmul_round #(.DW_IN(MW), .TW(TW)) u_cmul (
    .clk  (clk),
    .en   (adv),
    .i_ld (vld[1:0]),
    .i_mr (m1_re),
    .i_mi (m1_im),
    .i_wr (w1_re),
    .i_wi (w1_im),
    .o_zr (z_re),
    .o_zi (z_im)
  );

  // NOTE: every variable gets a default before the loop so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pre[0] = x_re_pre;
    pre[1] = x_im_pre;
    pre[2] = y_re_pre;
    pre[3] = y_im_pre;
    hit    = '0;
    for (int k = 0; k < 4; k++) begin
      scl[k] = '0;
      sat[k] = '0;
      res[k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      scl[k] = sc3 ? (pre[k] + EW'(1)) >>> 1 : pre[k];
      sat[k] = sat_dw(64'(scl[k]), DW);
      res[k] = sat[k][DW-1:0];
      hit[k] = (sat[k] != 64'(scl[k]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_xr <= '0;  o_xi <= '0;  o_yr <= '0;  o_yi <= '0;
      ovf4 <= 1'b0;
    end else if (adv && vld[2]) begin
      o_xr <= res[0];  o_xi <= res[1];
      o_yr <= res[2];  o_yi <= res[3];
      ovf4 <= |hit;
    end
  end

  // A saturated sample sets the flag as it is handed off; set beats clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_ovf <= 1'b0;
    else if (o_vld && o_rdy && ovf4) o_ovf <= 1'b1;
    else if (i_ovf_clr) o_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench: one DIT and one DIF instance driven with identical
// stimulus; expected results come from an integer model of the butterfly.
module tb_butterfly_pipe;

  localparam int DW  = 16;
  localparam int TW  = 16;
  localparam int LAT = 4;

  typedef struct {
    longint ar, ai, br, bi, wr, wi;
    bit     sc;
  } stim_t;

  typedef struct {
    longint xr, xi, yr, yi;
    int     acc;
    bit     lat;
  } exp_t;

  logic clk = 0;
  logic rst = 0;
  logic i_vld = 0, o_rdy = 1, i_scale = 0, i_ovf_clr = 0;
  logic signed [DW-1:0] i_ar = 0, i_ai = 0, i_br = 0, i_bi = 0;
  logic signed [TW-1:0] i_wr = 0, i_wi = 0;

  logic rdy_a, vld_a, ovf_a, rdy_b, vld_b, ovf_b;
  logic signed [DW-1:0] a_xr, a_xi, a_yr, a_yi, b_xr, b_xi, b_yr, b_yi;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_out [2];
  exp_t q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  butterfly_pipe #(.DW(DW), .TW(TW), .DIF(0)) dut_dit (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(rdy_a),
    .i_ar(i_ar), .i_ai(i_ai), .i_br(i_br), .i_bi(i_bi),
    .i_wr(i_wr), .i_wi(i_wi), .i_scale(i_scale),
    .o_vld(vld_a), .o_rdy(o_rdy),
    .o_xr(a_xr), .o_xi(a_xi), .o_yr(a_yr), .o_yi(a_yi),
    .o_ovf(ovf_a), .i_ovf_clr(i_ovf_clr)
  );

  butterfly_pipe #(.DW(DW), .TW(TW), .DIF(1)) dut_dif (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(rdy_b),
    .i_ar(i_ar), .i_ai(i_ai), .i_br(i_br), .i_bi(i_bi),
    .i_wr(i_wr), .i_wi(i_wi), .i_scale(i_scale),
    .o_vld(vld_b), .o_rdy(o_rdy),
    .o_xr(b_xr), .o_xi(b_xi), .o_yr(b_yr), .o_yi(b_yi),
    .o_ovf(ovf_b), .i_ovf_clr(i_ovf_clr)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic stim_t mk(longint ar, longint ai, longint br, longint bi,
                               longint wr, longint wi, bit sc);
    stim_t s;
    s.ar = ar; s.ai = ai; s.br = br; s.bi = bi; s.wr = wr; s.wi = wi; s.sc = sc;
    return s;
  endfunction

  // Integer reference: round half-up of the Q1.(TW-1) product, optional
  // halving with +1, then clamp to the DW-bit range.
  function automatic exp_t model(stim_t s, bit dif);
    exp_t   e;
    longint pr, pi, mr, mi, zr, zi, hi, lo, half;
    longint v [4];
    hi   = (longint'(1) <<< (DW - 1)) - 1;
    lo   = -hi - 1;
    half = longint'(1) <<< (TW - 2);
    if (dif) begin
      pr = s.ar + s.br;  pi = s.ai + s.bi;
      mr = s.ar - s.br;  mi = s.ai - s.bi;
    end else begin
      pr = s.ar;  pi = s.ai;  mr = s.br;  mi = s.bi;
    end
    zr = (mr * s.wr - mi * s.wi + half) >>> (TW - 1);
    zi = (mr * s.wi + mi * s.wr + half) >>> (TW - 1);
    if (dif) v = '{pr, pi, zr, zi};
    else     v = '{pr + zr, pi + zi, pr - zr, pi - zi};
    for (int k = 0; k < 4; k++) begin
      if (s.sc) v[k] = (v[k] + 1) >>> 1;
      if (v[k] > hi) v[k] = hi;
      else if (v[k] < lo) v[k] = lo;
    end
    e.xr = v[0]; e.xi = v[1]; e.yr = v[2]; e.yi = v[3];
    e.acc = 0; e.lat = 0;
    return e;
  endfunction

  task automatic apply(stim_t s);
    i_ar = DW'(s.ar); i_ai = DW'(s.ai); i_br = DW'(s.br); i_bi = DW'(s.bi);
    i_wr = TW'(s.wr); i_wi = TW'(s.wi); i_scale = s.sc;
  endtask

  task automatic push(stim_t s, bit lat);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e = model(s, d[0]);
      e.acc = cyc;
      e.lat = lat;
      q[d].push_back(e);
    end
  endtask

  // Holds the sample until both instances accept it; returns at posedge+1.
  task automatic send(stim_t s, bit lat);
    bit done = 0;
    apply(s);
    i_vld = 1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (rdy_a && rdy_b) begin
        push(s, lat);
        done = 1;
      end
      @(posedge clk); #1;
    end
    i_vld = 0;
    check("input accepted", longint'(done), 1);
  endtask

  // Returns at negedge+1 once both scoreboards are empty (or budget expires).
  task automatic drain();
    for (int k = 0; k < 50 && (q[0].size() + q[1].size()) != 0; k++) begin
      @(negedge clk); #1;
    end
    check("scoreboard drained", longint'(q[0].size() + q[1].size()), 0);
  endtask

  task automatic score(input int d, input string nm, input logic v,
                       input longint xr, input longint xi,
                       input longint yr, input longint yi);
    exp_t  e;
    string ph;
    if (!v) return;
    if (q[d].size() == 0) begin
      check({nm, " o_vld with empty scoreboard"}, longint'(v), 0);
      return;
    end
    e  = q[d][0];
    ph = o_rdy ? " out" : " stalled";
    check({nm, ph, " xr"}, xr, e.xr);
    check({nm, ph, " xi"}, xi, e.xi);
    check({nm, ph, " yr"}, yr, e.yr);
    check({nm, ph, " yi"}, yi, e.yi);
    if (o_rdy) begin
      if (e.lat) check({nm, " latency"}, longint'(cyc - e.acc), LAT);
      void'(q[d].pop_front());
      n_out[d]++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      score(0, "dit", vld_a, longint'(a_xr), longint'(a_xi), longint'(a_yr), longint'(a_yi));
      score(1, "dif", vld_b, longint'(b_xr), longint'(b_xi), longint'(b_yr), longint'(b_yi));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stim_t st [8];
    int    sent, base;

    n_out[0] = 0;
    n_out[1] = 0;

    // Reset state
    #3;
    check("reset o_vld dit", longint'(vld_a), 0);
    check("reset o_vld dif", longint'(vld_b), 0);
    check("reset o_ovf", longint'(ovf_a), 0);
    check("reset o_xr", longint'(a_xr), 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("i_rdy after release", longint'(rdy_a), 1);

    // Plain DIT/DIF cases with fixed latency
    send(mk(1000, 200, 300, -100, 32767, 0, 0), 1);
    send(mk(0, 0, 300, -100, 0, -32768, 0), 1);
    send(mk(100, 0, 50, 0, 0, -32768, 0), 1);
    drain();

    // Saturation, sticky flag and clear
    @(posedge clk); #1;
    send(mk(32767, 0, 32767, 0, 32767, 0, 0), 1);
    drain();
    check("ovf not yet set dit", longint'(ovf_a), 0);
    @(negedge clk);
    check("ovf set dit", longint'(ovf_a), 1);
    check("ovf set dif", longint'(ovf_b), 1);
    @(posedge clk); #1;
    i_ovf_clr = 1;
    @(posedge clk); #1;
    i_ovf_clr = 0;
    @(negedge clk);
    check("ovf cleared", longint'(ovf_a), 0);
    @(posedge clk); #1;
    send(mk(32767, 0, 32767, 0, 32767, 0, 1), 1);
    drain();
    @(negedge clk);
    check("ovf stays clear scaled dit", longint'(ovf_a), 0);
    check("ovf stays clear scaled dif", longint'(ovf_b), 0);

    // Backpressure: continuous stream, o_rdy low for cycles 6..8
    for (int k = 0; k < 8; k++)
      st[k] = mk(longint'($urandom_range(65535)) - 32768, longint'($urandom_range(65535)) - 32768,
                 longint'($urandom_range(65535)) - 32768, longint'($urandom_range(65535)) - 32768,
                 longint'($urandom_range(65535)) - 32768, longint'($urandom_range(65535)) - 32768,
                 $urandom_range(1) == 1);
    base = n_out[0];
    sent = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 40 && sent < 8; k++) begin
      apply(st[sent]);
      i_vld = 1;
      o_rdy = !(k >= 6 && k <= 8);
      @(negedge clk);
      check("stream i_rdy dit", longint'(rdy_a), (k >= 6 && k <= 8) ? 0 : 1);
      check("stream i_rdy dif", longint'(rdy_b), (k >= 6 && k <= 8) ? 0 : 1);
      if (rdy_a && rdy_b) begin
        push(st[sent], 0);
        sent++;
      end
      @(posedge clk); #1;
    end
    i_vld = 0;
    o_rdy = 1;
    check("stream all accepted", longint'(sent), 8);
    drain();
    check("stream output count", longint'(n_out[0] - base), 8);

    // Asynchronous reset with samples in flight
    @(posedge clk); #1;
    send(mk(32767, 0, 32767, 0, 32767, 0, 0), 1);
    drain();
    @(negedge clk);
    check("pre-reset ovf", longint'(ovf_a), 1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) send(mk(10 * k, -5 * k, 3, 4, 16384, -16384, 0), 0);
    #1;
    check("pre-reset o_vld", longint'(vld_a), 1);
    #1;
    rst = 0;
    #1;
    check("async reset o_vld dit", longint'(vld_a), 0);
    check("async reset o_vld dif", longint'(vld_b), 0);
    check("async reset o_ovf dit", longint'(ovf_a), 0);
    check("async reset o_ovf dif", longint'(ovf_b), 0);
    check("async reset o_xr", longint'(a_xr), 0);
    check("async reset o_yi", longint'(b_yi), 0);
    q[0].delete();
    q[1].delete();
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post-reset i_rdy", longint'(rdy_a), 1);
      check("post-reset no stale o_vld", longint'(vld_a | vld_b), 0);
    end
    @(posedge clk); #1;
    send(mk(-1234, 567, 890, -321, -32768, 0, 0), 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
